// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall / forward / flush controller for a 5-stage
// (IF, ID, EX, MEM, WB) pipeline.
//  - Operand-forward selects for the ID stage (EX result beats MEM result).
//  - Load-use interlock: one bubble into ID/EX while PC and IF/ID hold.
//  - Data-memory wait FSM (RUN/MWAIT) that freezes the pipe, with a
//    MAX_WAIT timeout that raises a sticky mem_timeout flag.
//  - Saturating count of cycles in which the PC did not advance.
// Optional build macro: BRANCH_FLUSH_EN
//   defined   -> flush_if squashes the fetch behind a taken branch
//   undefined -> flush_if tied low (delay-slot semantics)
// Note: resetn is an active-HIGH synchronous reset despite its name.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CW       = 16
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic          use_rs,
    input  logic          use_rt,
    input  logic          ewreg,
    input  logic          em2reg,
    input  logic [4:0]    ern,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          mwmem,
    input  logic [4:0]    mrn,
    input  logic          branch_taken,
    input  logic          dmem_ready,
    output logic          pc_en,
    output logic          if_id_en,
    output logic          id_ex_en,
    output logic          id_ex_bubble,
    output logic          ex_mem_en,
    output logic          mem_wb_bubble,
    output logic          flush_if,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb,
    output logic          mem_timeout,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic       rst;
    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       release_q, release_nxt;
    logic       tmo_set;
    logic       freeze;
    logic       lu;
    logic       memacc;

    assign rst = resetn;

    // Forward source for one ID operand; r0 is hard-wired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] e_rn,
        input logic       m_wreg,
        input logic       m_m2reg,
        input logic [4:0] m_rn
    );
        if (src == 5'd0)
            return 2'b00;
        else if (e_wreg && !e_m2reg && (e_rn == src))
            return 2'b01;
        else if (m_wreg && m_m2reg && (m_rn == src))
            return 2'b11;
        else if (m_wreg && (m_rn == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign memacc = mm2reg | mwmem;
    assign lu     = ewreg & em2reg & (ern != 5'd0) &
                    ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));

    // Memory-wait FSM next state; release_q grants one free cycle after a timeout
    // so the stuck access is treated as complete and the pipe moves on.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        release_nxt  = 1'b0;
        tmo_set      = 1'b0;
        freeze       = 1'b0;
        case (state)
            RUN: begin
                if (memacc && !dmem_ready && !release_q) begin
                    freeze       = 1'b1;
                    state_nxt    = MWAIT;
                    wait_cnt_nxt = 8'd1;
                end
            end
            MWAIT: begin
                freeze = !dmem_ready;
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == MAX_W) begin
                    tmo_set      = 1'b1;
                    release_nxt  = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Pipeline-register controls: reset forces a free-running pipe, freeze beats load-use.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        flush_if      = 1'b0;
        fwda          = 2'b00;
        fwdb          = 2'b00;
        if (!rst) begin
            fwda = fwd_sel(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
            fwdb = fwd_sel(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
            if (freeze) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (lu) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end
`ifdef BRANCH_FLUSH_EN
            flush_if = branch_taken & pc_en;
`endif
        end
    end

`ifndef BRANCH_FLUSH_EN
    logic unused_branch;
    assign unused_branch = branch_taken;
`endif

    // FSM state, wait counter, sticky timeout flag and stall counter.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            release_q   <= 1'b0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            release_q <= release_nxt;
            if (tmo_set)
                mem_timeout <= 1'b1;
            if (!pc_en)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/forward/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Generates write-enables and bubble-inserts for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and operand-forward selects for the ID stage.
- Sequences multi-cycle data-memory waits with an FSM and timeout, and counts stall cycles for performance monitoring.

Parameters:
- MAX_WAIT, 15, memory-wait cycles before timeout is declared (1..255).
- CW, 16, stall-counter width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous reset, active-high (port name kept per codebase port naming; asserted = 1).
- rs  in  5  ID-stage source register A.
- rt  in  5  ID-stage source register B.
- use_rs  in  1  ID instruction reads rs.
- use_rt  in  1  ID instruction reads rt.
- ewreg, em2reg  in  1 each  EX-stage write-reg / load flags.
- ern  in  5  EX-stage destination register.
- mwreg, mm2reg, mwmem  in  1 each  MEM-stage write-reg / load / store flags.
- mrn  in  5  MEM-stage destination register.
- branch_taken  in  1  ID-stage branch/jump resolved taken.
- dmem_ready  in  1  data memory completes the current MEM access this cycle.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID write enable.
- id_ex_en  out  1  ID/EX write enable.
- id_ex_bubble  out  1  load zero control into ID/EX.
- ex_mem_en  out  1  EX/MEM write enable.
- mem_wb_bubble  out  1  load zero control into MEM/WB.
- flush_if  out  1  squash IF/ID contents.
- fwda  out  2  rs source select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data.
- fwdb  out  2  rt source select, same encoding.
- mem_timeout  out  1  sticky wait-timeout flag.
- stall_cnt  out  CW  saturating count of cycles with pc_en=0.

Behaviour:
- Reset, synchronous: state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0.
- While resetn=1, outputs are forced: all *_en=1, bubbles=0, flush_if=0, fwda=fwdb=00.
- Register r0 is never forwarded and never causes a hazard.
- Forwarding (combinational, rs shown; rt identical):
  - 01 if ewreg & ~em2reg & ern==rs.
  - Else 11 if mwreg & mm2reg & mrn==rs.
  - Else 10 if mwreg & mrn==rs.
  - Else 00.
  - EX has priority over MEM.
- Load-use (lu), combinational: ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- memacc = mm2reg | mwmem.
- FSM states: RUN, MWAIT.
- RUN:
  - If memacc & ~dmem_ready: freeze = 1. Next state MWAIT, wait_cnt=1.
  - Else freeze = 0.
- MWAIT:
  - freeze = ~dmem_ready.
  - If dmem_ready: next state RUN, wait_cnt=0.
  - Else if wait_cnt==MAX_WAIT: set mem_timeout, next state RUN, and release the pipe on the following cycle (access treated as complete).
  - Else wait_cnt+1.
- freeze=1 (priority over lu):
  - pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, id_ex_bubble=0, flush_if=0.
- freeze=0, lu=1:
  - pc_en=if_id_en=0, id_ex_bubble=1, id_ex_en=1, ex_mem_en=1, mem_wb_bubble=0.
  - A taken branch in ID is held; no flush.
- Otherwise: all enables=1, bubbles=0.
- Latency: memacc with dmem_ready=1 in the same cycle costs zero stall cycles. A single-cycle lu stall resolves the next cycle, when the load reaches MEM and forwarding selects 11.
- stall_cnt increments every cycle pc_en=0 and saturates at 2^CW-1.
- mem_timeout clears only on reset.

Optional Feature:
- Macro: BRANCH_FLUSH_EN.
- Defined: flush_if = branch_taken & pc_en. The instruction fetched behind a taken branch is squashed (no delay slot).
- Undefined: flush_if is tied to 0 (delay-slot semantics).

Test Plan:
- Forwarding: ern=5, ewreg=1, em2reg=0, rs=5; plus mrn=5, mwreg=1 -> fwda=01 (EX wins). Drop EX -> fwda=10. Set mm2reg=1 -> fwda=11. rs=0 -> fwda=00.
- Load-use: ewreg=em2reg=1, ern=7, rt=7, use_rt=1 -> exactly 1 cycle of pc_en=0 and id_ex_bubble=1. Next cycle, with the load in MEM, fwdb=11. stall_cnt=1.
- Memory wait: mm2reg=1, dmem_ready low for 3 cycles then high -> 3 frozen cycles with mem_wb_bubble=1. FSM returns to RUN. stall_cnt=3.
- Timeout: MAX_WAIT=4, dmem_ready held 0 -> mem_timeout=1 after the 5th stall cycle, pipe released. Flag stays 1 until reset.
- Reset mid-wait: assert resetn during MWAIT -> next edge state=RUN, counters 0, enables=1.
- Branch: branch_taken=1 with no hazard -> flush_if=1 if BRANCH_FLUSH_EN is defined, else 0. Same branch coincident with lu -> flush_if=0.
